mk_xsim_top: RTL and testbench
==============================

# mk_xsim_top

Top-level portal endpoint for the xsim co-simulation build. It accepts 32-bit request message beats from the host-side sink and decodes portal method headers. It executes an echo method and a 16×32 register-file method set, and returns indication messages as 32-bit beats to the host-side source.

## Interface
Parameters:
- none

Ports:
- CLK  in  1  single clock; all logic on rising edge
- RST_N  in  1  asynchronous, active-low reset
- rq_valid  in  1  request beat present
- rq_beat  in  32  request beat data
- rq_ready  out  1  block accepts request beat this cycle
- ind_valid  out  1  indication beat present
- ind_beat  out  32  indication beat data
- ind_ready  in  1  host consumes indication beat this cycle
- err_unknown  out  1  sticky flag: an unknown method id was received

## Operation
- Message format, both directions:
  - Header word [31:16] = method id; [15:0] = total word count, header included.
  - Payload words follow the header.
- FSM states: HDR → ARGS → EXEC → RESP → HDR.
  - ARGS is skipped when the length field is 0 or 1.
  - EXEC goes directly to HDR when the method produces no indication.
- ARGS:
  - Only the first two payload words are stored, as arg0 and arg1.
  - Further payload words are accepted and discarded.
  - Missing arguments read as 0.
- Request methods:
  - 0 say(v): indication {16'd0,16'd2}, then v.
  - 1 setReg(idx,val): regs[idx[3:0]] <= val in EXEC; no indication.
  - 2 getReg(idx): indication {16'd1,16'd3}, then idx, then regs[idx[3:0]] (value sampled in EXEC).
  - 3 getCycles: see Configuration.
  - Any other id: payload is consumed and discarded, err_unknown is set, and no indication is sent.
- err_unknown is cleared only by reset.
- The register file is 16 entries × 32 bits.

## Timing
- Reset, asynchronous assert:
  - rq_ready = 0, ind_valid = 0, ind_beat = 0, err_unknown = 0.
  - All regs = 0, cycle counter = 0, FSM = HDR.
  - rq_ready rises on the first clock edge after RST_N deasserts.
- Reset mid-message or mid-indication: the partial message is discarded, ind_valid drops immediately, and no beat is replayed.
- rq_ready = 1 only in HDR and ARGS. A beat transfers on a rising edge with rq_valid && rq_ready.
- EXEC lasts exactly 1 cycle.
- In RESP:
  - ind_valid = 1 and ind_beat holds steady until ind_valid && ind_ready.
  - The next beat is presented on the following cycle, giving back-to-back beats at full throughput.
- After the final indication handshake the FSM is in HDR on the next cycle (rq_ready = 1).
- Latency for a header-only say: header accepted at edge N, ind_valid = 1 from cycle N+2.
- Width rules:
  - idx is truncated to 4 bits.
  - The cycle counter is 32 bits, increments every cycle out of reset, and wraps 0xFFFFFFFF → 0.
- A length field of 0 is treated as 1.

## Configuration
- MK_XSIM_TOP_CYCLE_COUNTER_EN defined:
  - The free-running 32-bit cycle counter exists.
  - Method 3 returns indication {16'd2,16'd2}, then the counter value sampled in EXEC.
- Not defined:
  - The counter is absent.
  - Method 3 is handled as an unknown id: payload discarded, err_unknown set, no indication.

## Test plan
- Reset: hold RST_N = 0 for 5 cycles and release. Required: rq_ready = 0 during reset; rq_ready = 1 after the first edge post-release; ind_valid = 0; err_unknown = 0.
- Echo: send 0x00000002, 0xDEADBEEF with ind_ready = 1. Required: indication beats 0x00000002, 0xDEADBEEF; ind_valid first high 2 cycles after the last request beat.
- Register round trip: send setReg (0x00010003, 0x15, 0x12345678), then getReg (0x00020002, 0x15). Required: indication 0x00010003, 0x00000015, 0x12345678 (index 5 used).
- Backpressure: during an echo indication hold ind_ready = 0 for 4 cycles. Required: ind_beat stable, rq_ready = 0, no beat lost or duplicated once ind_ready = 1.
- Unknown and extra payload: send 0x00070003, 1, 2. Required: all beats accepted, err_unknown = 1, no indication. Then send say 0x00000004, 0xA, 0xB, 0xC. Required: indication 0x00000002, 0x0000000A.
- Cycle counter:
  - With MK_XSIM_TOP_CYCLE_COUNTER_EN, issue 0x00030001 twice, 10 cycles apart. Required: header 0x00020002 each time; the two counts differ by the true cycle spacing.
  - Without the macro: err_unknown = 1 and no indication.

Source files
------------

// File: rtl/mk_xsim_top_if.sv
// Request and indication beat channels between the host portal and mk_xsim_top.
// The slave modport is the endpoint side; master is the host side.
interface mk_xsim_top_if;
    logic        rq_valid;
    logic [31:0] rq_beat;
    logic        rq_ready;
    logic        ind_valid;
    logic [31:0] ind_beat;
    logic        ind_ready;

    modport slave (
        input  rq_valid, rq_beat, ind_ready,
        output rq_ready, ind_valid, ind_beat
    );

    modport master (
        output rq_valid, rq_beat, ind_ready,
        input  rq_ready, ind_valid, ind_beat
    );
endinterface

// File: rtl/mk_xsim_top.sv
// xsim portal endpoint: decodes request messages, runs say / setReg / getReg / getCycles.
// Define MK_XSIM_TOP_CYCLE_COUNTER_EN to build the cycle counter and method 3.
module mk_xsim_top (
    input  logic         CLK,
    input  logic         RST_N,
    mk_xsim_top_if.slave bus,
    output logic         err_unknown
);

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_ARGS = 2'd1,
        S_EXEC = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_live;
    logic [15:0]         r_mid;
    logic [15:0]         r_left;
    logic [1:0]          r_argc;
    logic [31:0]         r_arg0;
    logic [31:0]         r_arg1;
    logic [15:0][31:0]   r_regs;
    logic [2:0][31:0]    r_resp;
    logic [1:0]          r_rlen;
    logic [1:0]          r_ridx;
    logic                r_err;
`ifdef MK_XSIM_TOP_CYCLE_COUNTER_EN
    logic [31:0]         r_cyc;
`endif

    logic                w_rq_fire;
    logic                w_ind_fire;
    logic [15:0]         w_hdr_len;
    logic                w_known;
    logic                w_has_ind;
    logic [1:0]          w_ind_len;
    logic [2:0][31:0]    w_ind;

    // r_live holds rq_ready low until the first edge after reset release
    assign bus.rq_ready  = r_live && ((r_state == S_HDR) || (r_state == S_ARGS));
    assign bus.ind_valid = (r_state == S_RESP);
    assign bus.ind_beat  = (r_state == S_RESP) ? r_resp[r_ridx] : 32'd0;
    assign err_unknown   = r_err;

    assign w_rq_fire  = bus.rq_valid && bus.rq_ready;
    assign w_ind_fire = bus.ind_valid && bus.ind_ready;
    assign w_hdr_len  = bus.rq_beat[15:0];

    // Method decode, only consumed while in EXEC
    always_comb begin
        w_known   = 1'b1;
        w_has_ind = 1'b0;
        w_ind_len = 2'd0;
        w_ind     = '0;
        case (r_mid)
            16'd0: begin
                w_has_ind = 1'b1;
                w_ind_len = 2'd2;
                w_ind[0]  = 32'h0000_0002;
                w_ind[1]  = r_arg0;
            end
            16'd1: ;
            16'd2: begin
                w_has_ind = 1'b1;
                w_ind_len = 2'd3;
                w_ind[0]  = 32'h0001_0003;
                w_ind[1]  = r_arg0;
                w_ind[2]  = r_regs[r_arg0[3:0]];
            end
`ifdef MK_XSIM_TOP_CYCLE_COUNTER_EN
            16'd3: begin
                w_has_ind = 1'b1;
                w_ind_len = 2'd2;
                w_ind[0]  = 32'h0002_0002;
                w_ind[1]  = r_cyc;
            end
`endif
            default: w_known = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_HDR: begin
                if (w_rq_fire)
                    w_state_nxt = (w_hdr_len <= 16'd1) ? S_EXEC : S_ARGS;
            end
            S_ARGS: begin
                if (w_rq_fire && (r_left == 16'd1))
                    w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                w_state_nxt = w_has_ind ? S_RESP : S_HDR;
            end
            S_RESP: begin
                if (w_ind_fire && (r_ridx == (r_rlen - 2'd1)))
                    w_state_nxt = S_HDR;
            end
            default: w_state_nxt = S_HDR;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_HDR;
            r_live  <= 1'b0;
            r_mid   <= '0;
            r_left  <= '0;
            r_argc  <= '0;
            r_arg0  <= '0;
            r_arg1  <= '0;
            r_resp  <= '0;
            r_rlen  <= '0;
            r_ridx  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_live  <= 1'b1;
            r_state <= w_state_nxt;
            case (r_state)
                S_HDR: begin
                    if (w_rq_fire) begin
                        r_mid  <= bus.rq_beat[31:16];
                        r_left <= (w_hdr_len == 16'd0) ? 16'd0 : w_hdr_len - 16'd1;
                        r_argc <= '0;
                        r_arg0 <= '0;
                        r_arg1 <= '0;
                    end
                end
                S_ARGS: begin
                    // Payload past the second word is accepted and dropped
                    if (w_rq_fire) begin
                        r_left <= r_left - 16'd1;
                        if (r_argc == 2'd0)
                            r_arg0 <= bus.rq_beat;
                        else if (r_argc == 2'd1)
                            r_arg1 <= bus.rq_beat;
                        if (r_argc != 2'd2)
                            r_argc <= r_argc + 2'd1;
                    end
                end
                S_EXEC: begin
                    if (!w_known)
                        r_err <= 1'b1;
                    if (w_has_ind) begin
                        r_resp <= w_ind;
                        r_rlen <= w_ind_len;
                        r_ridx <= '0;
                    end
                end
                S_RESP: begin
                    if (w_ind_fire)
                        r_ridx <= r_ridx + 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            r_regs <= '0;
        else if ((r_state == S_EXEC) && (r_mid == 16'd1))
            r_regs[r_arg0[3:0]] <= r_arg1;
    end

`ifdef MK_XSIM_TOP_CYCLE_COUNTER_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            r_cyc <= '0;
        else
            r_cyc <= r_cyc + 32'd1;
    end
`endif

endmodule

// File: tb/tb_mk_xsim_top.sv
// Bench for mk_xsim_top: message vector table with an indication scoreboard,
// plus hand sequences for reset, latency, backpressure and the cycle counter.
module tb_mk_xsim_top;

    logic CLK;
    logic RST_N;
    logic err_unknown;

    mk_xsim_top_if bus();

    mk_xsim_top u_dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .bus         (bus),
        .err_unknown (err_unknown)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int          nrq;
        logic [31:0] rq [4];
        int          nind;
        logic [31:0] ind [3];
        logic        err;
    } vec_t;

    vec_t        vecs [13];
    logic [31:0] q [$];
    logic [31:0] exp_w;
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          tcyc   = 0;
    logic        mon_en = 1'b1;

    always @(posedge CLK) tcyc <= tcyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Scoreboard side: every indication handshake pops one expected beat
    always @(negedge CLK) begin
        if (mon_en && RST_N && bus.ind_valid && bus.ind_ready) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL ind_extra got=%h want=none", bus.ind_beat);
            end else begin
                exp_w = q.pop_front();
                if (bus.ind_beat !== exp_w) begin
                    n_fail++;
                    $display("FAIL ind_beat got=%h want=%h", bus.ind_beat, exp_w);
                end
            end
        end
    end

    task automatic send_beat(input logic [31:0] w);
        int t = 0;
        bus.rq_valid = 1'b1;
        bus.rq_beat  = w;
        @(negedge CLK);
        while (!bus.rq_ready && t < 50) begin
            @(negedge CLK);
            t++;
        end
        chk("rq_accept_timeout", {31'd0, bus.rq_ready}, 32'd1);
        @(posedge CLK);
        #1;
        bus.rq_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        @(negedge CLK);
        while ((q.size() != 0 || !bus.rq_ready) && t < 300) begin
            @(negedge CLK);
            t++;
        end
        chk({name, "_drain"}, q.size(), 32'd0);
        q.delete();
        @(posedge CLK);
        #1;
    endtask

    task automatic get_ind(output logic [31:0] w);
        int t = 0;
        @(negedge CLK);
        while (!bus.ind_valid && t < 50) begin
            @(negedge CLK);
            t++;
        end
        chk("ind_timeout", {31'd0, bus.ind_valid}, 32'd1);
        w = bus.ind_beat;
        @(posedge CLK);
        #1;
    endtask

    task automatic set_vec(input int k, input int nrq,
                           input logic [31:0] r0, input logic [31:0] r1,
                           input logic [31:0] r2, input logic [31:0] r3,
                           input int nind, input logic [31:0] i0,
                           input logic [31:0] i1, input logic [31:0] i2,
                           input logic e);
        vecs[k].nrq    = nrq;
        vecs[k].rq[0]  = r0;
        vecs[k].rq[1]  = r1;
        vecs[k].rq[2]  = r2;
        vecs[k].rq[3]  = r3;
        vecs[k].nind   = nind;
        vecs[k].ind[0] = i0;
        vecs[k].ind[1] = i1;
        vecs[k].ind[2] = i2;
        vecs[k].err    = e;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] h, c1, c2;
        int          a1, a2;

        set_vec( 0, 2, 32'h0000_0002, 32'hDEAD_BEEF, 0, 0, 2, 32'h0000_0002, 32'hDEAD_BEEF, 0, 1'b0);
        set_vec( 1, 3, 32'h0001_0003, 32'h15, 32'h1234_5678, 0, 0, 0, 0, 0, 1'b0);
        set_vec( 2, 2, 32'h0002_0002, 32'h15, 0, 0, 3, 32'h0001_0003, 32'h15, 32'h1234_5678, 1'b0);
        set_vec( 3, 2, 32'h0002_0002, 32'h3, 0, 0, 3, 32'h0001_0003, 32'h3, 32'h0, 1'b0);
        set_vec( 4, 1, 32'h0000_0001, 0, 0, 0, 2, 32'h0000_0002, 32'h0, 0, 1'b0);
        set_vec( 5, 1, 32'h0000_0000, 0, 0, 0, 2, 32'h0000_0002, 32'h0, 0, 1'b0);
        set_vec( 6, 3, 32'h0001_0003, 32'h1F, 32'hA5A5_A5A5, 0, 0, 0, 0, 0, 1'b0);
        set_vec( 7, 2, 32'h0002_0002, 32'hFF, 0, 0, 3, 32'h0001_0003, 32'hFF, 32'hA5A5_A5A5, 1'b0);
        set_vec( 8, 3, 32'h0001_0003, 32'h7, 32'h11, 0, 0, 0, 0, 0, 1'b0);
        set_vec( 9, 2, 32'h0001_0002, 32'h7, 0, 0, 0, 0, 0, 0, 1'b0);
        set_vec(10, 2, 32'h0002_0002, 32'h7, 0, 0, 3, 32'h0001_0003, 32'h7, 32'h0, 1'b0);
        set_vec(11, 3, 32'h0007_0003, 32'h1, 32'h2, 0, 0, 0, 0, 0, 1'b1);
        set_vec(12, 4, 32'h0000_0004, 32'hA, 32'hB, 32'hC, 2, 32'h0000_0002, 32'hA, 0, 1'b1);

        bus.rq_valid  = 1'b0;
        bus.rq_beat   = '0;
        bus.ind_ready = 1'b0;
        RST_N = 1'b1;
        #1 RST_N = 1'b0;

        // Reset: outputs quiet while held, rq_ready rises one edge after release
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        chk("rst_rq_ready",  {31'd0, bus.rq_ready},  32'd0);
        chk("rst_ind_valid", {31'd0, bus.ind_valid}, 32'd0);
        chk("rst_ind_beat",  bus.ind_beat,           32'd0);
        chk("rst_err",       {31'd0, err_unknown},   32'd0);
        @(posedge CLK);
        #1 RST_N = 1'b1;
        @(negedge CLK);
        chk("rel_rq_ready_pre", {31'd0, bus.rq_ready}, 32'd0);
        @(negedge CLK);
        chk("rel_rq_ready_post", {31'd0, bus.rq_ready}, 32'd1);
        chk("rel_ind_valid", {31'd0, bus.ind_valid}, 32'd0);
        @(posedge CLK);
        #1;

        // Echo latency: ind_valid two cycles after the last request beat
        bus.ind_ready = 1'b1;
        q.push_back(32'h0000_0002);
        q.push_back(32'h1234_5678);
        send_beat(32'h0000_0002);
        send_beat(32'h1234_5678);
        @(negedge CLK);
        chk("lat_exec_ind_valid", {31'd0, bus.ind_valid}, 32'd0);
        @(negedge CLK);
        chk("lat_resp_ind_valid", {31'd0, bus.ind_valid}, 32'd1);
        wait_drain("latency");

        for (int k = 0; k < 13; k++) begin
            for (int j = 0; j < vecs[k].nind; j++) q.push_back(vecs[k].ind[j]);
            for (int j = 0; j < vecs[k].nrq; j++) send_beat(vecs[k].rq[j]);
            wait_drain($sformatf("vec%0d", k));
            chk($sformatf("vec%0d_err", k), {31'd0, err_unknown}, {31'd0, vecs[k].err});
        end

        // Backpressure: first beat held stable and no request accepted
        bus.ind_ready = 1'b0;
        q.push_back(32'h0000_0002);
        q.push_back(32'hCAFE_F00D);
        send_beat(32'h0000_0002);
        send_beat(32'hCAFE_F00D);
        begin
            int t = 0;
            @(negedge CLK);
            while (!bus.ind_valid && t < 50) begin
                @(negedge CLK);
                t++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            chk("bp_ind_valid", {31'd0, bus.ind_valid}, 32'd1);
            chk("bp_ind_beat",  bus.ind_beat,           32'h0000_0002);
            chk("bp_rq_ready",  {31'd0, bus.rq_ready},  32'd0);
            @(negedge CLK);
        end
        @(posedge CLK);
        #1 bus.ind_ready = 1'b1;
        wait_drain("backpressure");

        // Reset mid-indication: beat withdrawn at once, nothing replayed after
        bus.ind_ready = 1'b0;
        send_beat(32'h0000_0002);
        send_beat(32'h5555_5555);
        begin
            int t = 0;
            @(negedge CLK);
            while (!bus.ind_valid && t < 50) begin
                @(negedge CLK);
                t++;
            end
        end
        chk("mid_ind_valid_pre", {31'd0, bus.ind_valid}, 32'd1);
        #2 RST_N = 1'b0;
        #1;
        chk("mid_ind_valid_rst", {31'd0, bus.ind_valid}, 32'd0);
        chk("mid_err_rst",       {31'd0, err_unknown},   32'd0);
        @(posedge CLK);
        #1 RST_N = 1'b1;
        bus.ind_ready = 1'b1;
        q.push_back(32'h0000_0002);
        q.push_back(32'h0000_0077);
        send_beat(32'h0000_0002);
        send_beat(32'h0000_0077);
        wait_drain("post_reset");

`ifdef MK_XSIM_TOP_CYCLE_COUNTER_EN
        mon_en = 1'b0;
        send_beat(32'h0003_0001);
        a1 = tcyc;
        get_ind(h);
        chk("cyc1_hdr", h, 32'h0002_0002);
        get_ind(c1);
        repeat (10) @(posedge CLK);
        #1;
        send_beat(32'h0003_0001);
        a2 = tcyc;
        get_ind(h);
        chk("cyc2_hdr", h, 32'h0002_0002);
        get_ind(c2);
        chk("cyc_delta", c2 - c1, a2 - a1);
        mon_en = 1'b1;
        wait_drain("cycles");
        chk("cyc_err", {31'd0, err_unknown}, 32'd0);
`else
        h = '0; c1 = '0; c2 = '0; a1 = 0; a2 = 0;
        send_beat(32'h0003_0001);
        wait_drain("cycles_off");
        chk("cyc_off_err", {31'd0, err_unknown}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
